// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles every bus signal of dmem_arbiter: the two requester ports and the
//   connection to the single-port dataMemory.
//   Modports:
//     slave  - the arbiter: takes requests and mem_RD, drives responses and
//              the memory address/data/write-enable.
//     master - the environment: both requesters plus the dataMemory.
//   Signals per requester n in {0,1}:
//     reqn, wen, addrn, wdatan   request and its payload (held until readyn)
//     readyn                     one-cycle accept pulse
//     rvalidn, rerrn, rdatan     one-cycle response; rdatan holds between responses
//   Memory side: mem_A, mem_WD, mem_WE (to dataMemory), mem_RD (from dataMemory).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req0,    req1;
   logic              we0,     we1;
   logic [ADDR_W-1:0] addr0,   addr1;
   logic [DATA_W-1:0] wdata0,  wdata1;
   logic              ready0,  ready1;
   logic              rvalid0, rvalid1;
   logic              rerr0,   rerr1;
   logic [DATA_W-1:0] rdata0,  rdata1;

   logic [ADDR_W-1:0] mem_A;
   logic [DATA_W-1:0] mem_WD;
   logic              mem_WE;
   logic [DATA_W-1:0] mem_RD;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_RD,
      output ready0, ready1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
             mem_A, mem_WD, mem_WE
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_RD,
      input  ready0, ready1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1,
             mem_A, mem_WD, mem_WE
   );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port dataMemory between the core load/store unit (port 0)
//   and the debug/loader port (port 1). Round-robin arbitration; a granted
//   request is latched and performs exactly one memory access, then a one-cycle
//   response is returned to its owner. Misaligned or out-of-range accesses do
//   not touch memory and respond with rerr=1, rdata=0.
//   Every transaction walks IDLE -> ACCESS -> RESP -> IDLE (3 cycles).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    dmem_arbiter_if.slave: requester ports 0/1 and the dataMemory side
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Highest legal word address, compared unsigned at full address width.
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

   state_t            state, state_nxt;
   logic              rr_ptr;      // port that wins the next tie
   logic              lat_port;    // owner of the transaction in flight
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              rerr_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic              grant_vld;
   logic              grant_port;
   logic              legal;
   logic [DATA_W-1:0] rd_capture;

   // A lone requester wins outright; a tie goes to rr_ptr.
   assign grant_vld  = bus.req0 | bus.req1;
   assign grant_port = (bus.req0 & bus.req1) ? rr_ptr : bus.req1;

   assign legal      = (lat_addr[1:0] == 2'b00) && (lat_addr <= LAST_WORD);

   // Reads return memory data; writes and rejected accesses return zero.
   assign rd_capture = (lat_we || !legal) ? '0 : bus.mem_RD;

   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;

   // ---------------------------------------------------------------- state reg
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ------------------------------------------------- next state and outputs
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      bus.ready0  = 1'b0;
      bus.ready1  = 1'b0;
      bus.rvalid0 = 1'b0;
      bus.rvalid1 = 1'b0;
      bus.rerr0   = 1'b0;
      bus.rerr1   = 1'b0;
      bus.mem_A   = '0;
      bus.mem_WD  = '0;
      bus.mem_WE  = 1'b0;

      case (state)
         IDLE: begin
            if (grant_vld) begin
               bus.ready0 = ~grant_port;
               bus.ready1 =  grant_port;
               state_nxt  = ACCESS;
            end
         end

         ACCESS: begin
            bus.mem_A  = lat_addr;
            bus.mem_WD = lat_wdata;
            bus.mem_WE = lat_we & legal;
            state_nxt  = RESP;
         end

         RESP: begin
            bus.rvalid0 = ~lat_port;
            bus.rvalid1 =  lat_port;
            bus.rerr0   = ~lat_port & rerr_q;
            bus.rerr1   =  lat_port & rerr_q;
            state_nxt   = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------ latched transaction
   // NOTE: all datapath registers are reset so no output can show stale or
   // unknown data after reset, including the held rdata values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= 1'b0;
         lat_port  <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rerr_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         if (state == IDLE && grant_vld) begin
            lat_port  <= grant_port;
            rr_ptr    <= ~grant_port;
            if (grant_port) begin
               lat_we    <= bus.we1;
               lat_addr  <= bus.addr1;
               lat_wdata <= bus.wdata1;
            end else begin
               lat_we    <= bus.we0;
               lat_addr  <= bus.addr0;
               lat_wdata <= bus.wdata0;
            end
         end

         // Only the owner's rdata changes; the other port keeps its last value.
         if (state == ACCESS) begin
            rerr_q <= ~legal;
            if (lat_port) rdata1_q <= rd_capture;
            else          rdata0_q <= rd_capture;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A behavioural dataMemory sits on the
//   memory side. A transaction-level reference model predicts, per cycle, which
//   port is accepted, the memory access one cycle later and the response two
//   cycles later, from the arbitration rules and a reference copy of memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int MEM_BYTES = 1024;
   localparam int WORDS     = MEM_BYTES / 4;

   logic clk = 1'b0;
   logic rst_n;
   logic preload;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   dmem_arbiter #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .MEM_BYTES(MEM_BYTES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // ------------------------------------------------------------ dataMemory
   logic [31:0] mem [WORDS];

   function automatic logic [31:0] mem_init(input int i);
      return (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
   endfunction

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < WORDS; i++) mem[i] <= mem_init(i);
      end else if (bus.mem_WE) begin
         mem[bus.mem_A[9:2]] <= bus.mem_WD;
      end
   end

   // Out-of-range reads return a non-zero pattern so a missing zeroing shows up.
   assign bus.mem_RD = (bus.mem_A < MEM_BYTES) ? mem[bus.mem_A[9:2]] : 32'hA5A5_A5A5;

   // ------------------------------------------------------------ bookkeeping
   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ------------------------------------------------------- reference model
   logic [31:0] ref_mem [WORDS];
   int          free_at;       // first cycle the arbiter may accept again
   int          t_start;       // cycle the current transaction was accepted
   bit          ptr;           // port favoured on a tie
   int          t_port;
   bit          t_we, t_err;
   logic [31:0] t_addr, t_wdata, t_rdata;
   logic [31:0] last_rdata [2];

   // Requester stimulus: a pending request is held until its ready is seen.
   bit          p_req [2];
   bit          p_we  [2];
   logic [31:0] p_addr  [2];
   logic [31:0] p_wdata [2];

   // Observed DUT behaviour for sequence-level checks.
   int obs_grants [$];
   int obs_resps = 0;

   function automatic bit is_legal(input logic [31:0] a);
      return (a % 4 == 0) && (a < MEM_BYTES);
   endfunction

   task automatic model_reset();
      free_at       = cyc;
      t_start       = -100;
      ptr           = 1'b0;
      last_rdata[0] = '0;
      last_rdata[1] = '0;
      p_req[0]      = 1'b0;
      p_req[1]      = 1'b0;
   endtask

   task automatic drive_inputs();
      bus.req0   = p_req[0];
      bus.we0    = p_we[0];
      bus.addr0  = p_addr[0];
      bus.wdata0 = p_wdata[0];
      bus.req1   = p_req[1];
      bus.we1    = p_we[1];
      bus.addr1  = p_addr[1];
      bus.wdata1 = p_wdata[1];
   endtask

   // One clock cycle: drive on the falling edge, predict, compare, advance.
   task automatic step();
      bit          gnt;
      int          w;
      bit   [1:0]  exp_rdy, exp_rv, exp_re;
      bit          exp_we;
      logic [31:0] exp_a, exp_wd;

      @(negedge clk);
      drive_inputs();
      #1;

      gnt = 1'b0;
      w   = 0;
      if (cyc >= free_at) begin
         if (p_req[0] && p_req[1]) begin gnt = 1'b1; w = int'(ptr); end
         else if (p_req[0])        begin gnt = 1'b1; w = 0;         end
         else if (p_req[1])        begin gnt = 1'b1; w = 1;         end
      end
      exp_rdy = '0;
      if (gnt) exp_rdy[w] = 1'b1;

      exp_we = 1'b0;
      exp_a  = '0;
      exp_wd = '0;
      if (cyc == t_start + 1) begin
         t_err   = !is_legal(t_addr);
         exp_a   = t_addr;
         exp_wd  = t_wdata;
         exp_we  = t_we && !t_err;
         t_rdata = (t_we || t_err) ? 32'h0 : ref_mem[t_addr[9:2]];
         if (exp_we) ref_mem[t_addr[9:2]] = t_wdata;
      end

      exp_rv = '0;
      exp_re = '0;
      if (cyc == t_start + 2) begin
         exp_rv[t_port]     = 1'b1;
         exp_re[t_port]     = t_err;
         last_rdata[t_port] = t_rdata;
      end

      check("ready0",  bus.ready0,  exp_rdy[0]);
      check("ready1",  bus.ready1,  exp_rdy[1]);
      check("mem_WE",  bus.mem_WE,  exp_we);
      check("mem_A",   bus.mem_A,   exp_a);
      check("mem_WD",  bus.mem_WD,  exp_wd);
      check("rvalid0", bus.rvalid0, exp_rv[0]);
      check("rvalid1", bus.rvalid1, exp_rv[1]);
      check("rerr0",   bus.rerr0,   exp_re[0]);
      check("rerr1",   bus.rerr1,   exp_re[1]);
      check("rdata0",  bus.rdata0,  last_rdata[0]);
      check("rdata1",  bus.rdata1,  last_rdata[1]);

      if (gnt) begin
         t_start = cyc;
         free_at = cyc + 3;
         t_port  = w;
         t_we    = p_we[w];
         t_addr  = p_addr[w];
         t_wdata = p_wdata[w];
         ptr     = (w == 0);
      end

      if (bus.ready0) obs_grants.push_back(0);
      if (bus.ready1) obs_grants.push_back(1);
      if (bus.rvalid0 || bus.rvalid1) obs_resps++;
      if (bus.ready0) p_req[0] = 1'b0;
      if (bus.ready1) p_req[1] = 1'b0;
      cyc++;
   endtask

   // Issue one request, wait (bounded) for acceptance, then let it complete.
   task automatic do_op(input int port, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
      int n = 0;
      p_req[port]   = 1'b1;
      p_we[port]    = we;
      p_addr[port]  = addr;
      p_wdata[port] = wdata;
      while (p_req[port] && n < 20) begin
         step();
         n++;
      end
      check("grant_wait", 32'(p_req[port]), 32'h0);
      p_req[port] = 1'b0;
      step();
      step();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready0"},  bus.ready0,  1'b0);
      check({tag, "_ready1"},  bus.ready1,  1'b0);
      check({tag, "_rvalid0"}, bus.rvalid0, 1'b0);
      check({tag, "_rvalid1"}, bus.rvalid1, 1'b0);
      check({tag, "_rerr0"},   bus.rerr0,   1'b0);
      check({tag, "_rerr1"},   bus.rerr1,   1'b0);
      check({tag, "_rdata0"},  bus.rdata0,  32'h0);
      check({tag, "_rdata1"},  bus.rdata1,  32'h0);
      check({tag, "_mem_WE"},  bus.mem_WE,  1'b0);
      check({tag, "_mem_A"},   bus.mem_A,   32'h0);
      check({tag, "_mem_WD"},  bus.mem_WD,  32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      drive_inputs();
      rst_n = 1'b0;
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return 32'($urandom_range(0, WORDS - 1) * 4) | 32'($urandom_range(1, 3));
         1:       return 32'(MEM_BYTES) + 32'($urandom_range(0, 63) * 4);
         2:       return 32'hFFFF_FFFC;
         3:       return 32'(MEM_BYTES - 4);
         default: return 32'($urandom_range(0, WORDS - 1) * 4);
      endcase
   endfunction

   // ------------------------------------------------------------- watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
      $fatal(1);
   end

   // ------------------------------------------------------------- sequence
   initial begin
      logic [31:0] old8;
      int          n;
      int          issued [2];
      int          resps_before;

      for (int i = 0; i < WORDS; i++) ref_mem[i] = mem_init(i);
      for (int k = 0; k < 2; k++) begin
         p_req[k] = 1'b0; p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0;
      end
      drive_inputs();
      preload = 1'b1;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_outputs_zero("por");
      preload = 1'b0;
      rst_n   = 1'b1;
      model_reset();

      // Write then read on port 0.
      do_op(0, 1'b1, 32'h4, 32'h2);
      do_op(0, 1'b0, 32'h4, 32'h0);
      check("wr_rd_rdata0", bus.rdata0, 32'h2);

      // Contention from reset: 4 writes per port, grants must alternate.
      do_reset();
      obs_grants.delete();
      resps_before = obs_resps;
      issued[0] = 0;
      issued[1] = 0;
      for (int i = 0; i < 24; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!p_req[k] && issued[k] < 4) begin
               p_req[k]   = 1'b1;
               p_we[k]    = 1'b1;
               p_addr[k]  = 32'h40 + 32'(k) * 32'h40 + 32'(issued[k]) * 4;
               p_wdata[k] = $urandom;
               issued[k]++;
            end
         end
         step();
      end
      check("cont_resps",  32'(obs_resps - resps_before), 32'd8);
      check("cont_grants", 32'(obs_grants.size()), 32'd8);
      for (int i = 0; i < obs_grants.size(); i++)
         check("cont_order", 32'(obs_grants[i]), 32'(i % 2));

      // Illegal accesses, then confirm 0x4 untouched.
      do_op(0, 1'b1, 32'h6, 32'hFFFF_0000);
      do_op(1, 1'b0, 32'(MEM_BYTES), 32'h0);
      check("oor_rdata1", bus.rdata1, 32'h0);
      do_op(0, 1'b0, 32'h4, 32'h0);
      check("readback_0x4", bus.rdata0, 32'h2);

      // Reset during the ACCESS cycle of a port-0 write to 0x8.
      old8 = ref_mem[2];
      p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 32'h8; p_wdata[0] = 32'h55;
      n = 0;
      while (p_req[0] && n < 20) begin step(); n++; end
      check("rst_grant_wait", 32'(p_req[0]), 32'h0);
      @(negedge clk);
      p_req[0] = 1'b0;
      drive_inputs();
      #1;
      check("rst_pre_we", bus.mem_WE, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_async_we",   bus.mem_WE,  1'b0);
      check("rst_async_A",    bus.mem_A,   32'h0);
      check("rst_rvalid0",    bus.rvalid0, 1'b0);
      @(negedge clk);
      check("rst_no_rvalid0", bus.rvalid0, 1'b0);
      rst_n = 1'b1;
      model_reset();
      // Tie right after reset must go to port 0.
      obs_grants.delete();
      p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 32'h8; p_wdata[0] = '0;
      p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 32'hC; p_wdata[1] = '0;
      for (int i = 0; i < 6; i++) step();
      check("rst_first_grant", 32'(obs_grants.size() > 0 ? obs_grants[0] : 9), 32'd0);
      check("rst_old_0x8", bus.rdata0, old8);

      // Port 1 alone.
      do_op(1, 1'b1, 32'h0, 32'hDEAD_BEEF);
      do_op(1, 1'b0, 32'h0, 32'h0);
      check("p1_rdata1", bus.rdata1, 32'hDEAD_BEEF);

      // req1 pulses for one cycle while port 0 is being served.
      obs_grants.delete();
      p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 32'h4; p_wdata[0] = '0;
      step();
      p_req[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 32'h10; p_wdata[1] = 32'h1234_5678;
      step();
      p_req[1] = 1'b0;
      step();
      step();
      check("withdraw_grants", 32'(obs_grants.size()), 32'd1);

      // Randomized traffic with occasional withdrawals.
      for (int i = 0; i < 500; i++) begin
         for (int k = 0; k < 2; k++) begin
            if (!p_req[k]) begin
               if ($urandom_range(0, 2) == 0) begin
                  p_req[k]   = 1'b1;
                  p_we[k]    = $urandom_range(0, 1) == 1;
                  p_addr[k]  = rand_addr();
                  p_wdata[k] = $urandom;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               p_req[k] = 1'b0;
            end
         end
         step();
      end
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
